// File: rtl/game_ctrl.sv
// Game-side controller: conditions the flap button and pause switch, runs the IDLE/PLAY/PAUSE/LOST
// game FSM, and keeps the current and high score as 4-digit BCD.
module game_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 2,
  parameter int          LOST_HOLD       = 100,
  parameter logic [15:0] MAX_SCORE       = 16'h9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flap_btn,
  input  logic        pause_sw,
  input  logic        collision,
  input  logic        pillar_passed,
  output logic [1:0]  game_state,
  output logic        flap_pulse,
  output logic        game_rst,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        lost,
  output logic        new_high
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LOST_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    LOST  = 2'b11
  } state_t;

  // Index 0 carries flap_btn, index 1 carries pause_sw.
  logic [1:0]    sync1_q, sync2_q, deb_q;
  logic [CW-1:0] db_cnt_q [2];
  logic          flap_deb_prev_q;
  logic          flap_edge_q;

  state_t        state_q, state_n;
  logic [15:0]   score_q, score_n;
  logic [15:0]   high_q, high_n;
  logic          new_high_q, new_high_n;
  logic [HW-1:0] hold_q, hold_n;
  logic          flap_pulse_q, flap_pulse_n;
  logic          game_rst_q, game_rst_n;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Input conditioning: the debounced level follows the synchronized input only after
  // DEBOUNCE_CYCLES consecutive samples that disagree with the current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      deb_q           <= '0;
      db_cnt_q[0]     <= '0;
      db_cnt_q[1]     <= '0;
      flap_deb_prev_q <= 1'b0;
      flap_edge_q     <= 1'b0;
    end else begin
      sync1_q <= {pause_sw, flap_btn};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
        end
      end
      flap_deb_prev_q <= deb_q[0];
      flap_edge_q     <= deb_q[0] & ~flap_deb_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      score_q      <= '0;
      high_q       <= '0;
      new_high_q   <= 1'b0;
      hold_q       <= '0;
      flap_pulse_q <= 1'b0;
      game_rst_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      score_q      <= score_n;
      high_q       <= high_n;
      new_high_q   <= new_high_n;
      hold_q       <= hold_n;
      flap_pulse_q <= flap_pulse_n;
      game_rst_q   <= game_rst_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    score_n      = score_q;
    high_n       = high_q;
    new_high_n   = new_high_q;
    hold_n       = hold_q;
    flap_pulse_n = 1'b0;
    game_rst_n   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flap_edge_q) begin
          state_n    = PLAY;
          game_rst_n = 1'b1;
          score_n    = '0;
          new_high_n = 1'b0;
        end
      end
      PLAY: begin
        if (collision) begin
          // High score is settled on the entry edge so it is visible the first LOST cycle.
          state_n = LOST;
          hold_n  = '0;
          if (score_q > high_q) begin
            high_n     = score_q;
            new_high_n = 1'b1;
          end
        end else begin
          if (deb_q[1]) begin
            state_n = PAUSE;
          end else if (flap_edge_q) begin
            flap_pulse_n = 1'b1;
          end
          if (pillar_passed && (score_q != MAX_SCORE)) begin
            score_n = bcd_inc(score_q);
          end
        end
      end
      PAUSE: begin
        if (!deb_q[1]) begin
          state_n = PLAY;
        end
      end
      LOST: begin
        if (hold_q != HW'(LOST_HOLD)) begin
          hold_n = hold_q + HW'(1);
        end else if (flap_edge_q) begin
          state_n    = PLAY;
          game_rst_n = 1'b1;
          score_n    = '0;
          new_high_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign game_state = state_q;
  assign lost       = (state_q == LOST);
  assign flap_pulse = flap_pulse_q;
  assign game_rst   = game_rst_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;

endmodule
